// File: rtl/wb_drain_pkg.sv
// Shared definitions for the write-buffer drain path: state encoding and
// geometry of the default line/word configuration.
package wb_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int unsigned DEF_DATASIZE   = 64;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned WORDS          = 8 * DEF_DATASIZE / DEF_DATA_WIDTH;
  localparam int unsigned OFFSET_BITS    = $clog2(DEF_DATASIZE);
  localparam int unsigned INDEX_BITS     = $clog2(WORDS);

endpackage

// File: rtl/write_buffer_drain_mask_to_strobe.sv
// Collapses a word-wide bit mask into per-byte write strobes: a byte is
// strobed when any of its eight mask bits is set.
module mask_to_strobe #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   mask,
  output logic [DATA_WIDTH/8-1:0] strobe
);

  // OR-reduce each byte lane of the mask
  always_comb begin
    strobe = '0;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      strobe[b] = |mask[8*b +: 8];
    end
  end

endmodule

// File: rtl/write_buffer_drain.sv
// Drains one latched cache line into the word-wide memory port, one word
// per accepted request, skipping words whose strobes are all zero, and
// pulses done once the last word has been written or skipped.
module write_buffer_drain
  import wb_drain_pkg::*;
#(
  parameter int unsigned ADDRESSIZE = 32,
  parameter int unsigned DATASIZE   = 64,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic [ADDRESSIZE-1:0]   address_in,
  input  logic [8*DATASIZE-1:0]   data_in,
  input  logic [8*DATASIZE-1:0]   mask_in,
  output logic                    done,
  output logic                    busy,
  output logic                    protocol_error,
  output logic                    mem_req,
  output logic [ADDRESSIZE-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready
);

  localparam int unsigned N_WORDS   = 8 * DATASIZE / DATA_WIDTH;
  localparam int unsigned OFF_BITS  = $clog2(DATASIZE);
  localparam int unsigned IDX_BITS  = $clog2(N_WORDS);
  localparam int unsigned BYTE_BITS = OFF_BITS - IDX_BITS;
  localparam int unsigned HI_BITS   = ADDRESSIZE - OFF_BITS;
  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_WORDS - 1);

  state_t                state;
  logic [IDX_BITS-1:0]   index;
  logic [HI_BITS-1:0]    line_q;
  logic [8*DATASIZE-1:0] data_q;
  logic [8*DATASIZE-1:0] mask_q;

  logic [HI_BITS-1:0]    nxt_hi;
  logic [IDX_BITS-1:0]   nxt_idx;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [DATA_WIDTH-1:0] nxt_mask;
  logic [STRB_W-1:0]     nxt_strb;
  logic [ADDRESSIZE-1:0] nxt_addr;

  // Line offset bits of the request address carry no information.
  logic unused_offset;
  assign unused_offset = ^address_in[OFF_BITS-1:0];

  // Word to present after the next edge: word 0 of the incoming request
  // when starting a line, otherwise the following word of the latched line.
  // Preloading here keeps every memory-side output a plain register.
  always_comb begin
    nxt_hi   = address_in[ADDRESSIZE-1:OFF_BITS];
    nxt_idx  = '0;
    nxt_data = data_in[DATA_WIDTH-1:0];
    nxt_mask = mask_in[DATA_WIDTH-1:0];
    if (state == ISSUE) begin
      nxt_hi   = line_q;
      nxt_idx  = index + IDX_BITS'(1);
      nxt_data = data_q[DATA_WIDTH*nxt_idx +: DATA_WIDTH];
      nxt_mask = mask_q[DATA_WIDTH*nxt_idx +: DATA_WIDTH];
    end
    nxt_addr = {nxt_hi, nxt_idx, {BYTE_BITS{1'b0}}};
  end

  mask_to_strobe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mask_to_strobe (
    .mask  (nxt_mask),
    .strobe(nxt_strb)
  );

  // Request sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      index          <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      protocol_error <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (write_enable) begin
            line_q    <= address_in[ADDRESSIZE-1:OFF_BITS];
            data_q    <= data_in;
            mask_q    <= mask_in;
            index     <= '0;
            state     <= ISSUE;
            busy      <= 1'b1;
            mem_req   <= |nxt_strb;
            mem_addr  <= nxt_addr;
            mem_wdata <= nxt_data;
            mem_wstrb <= nxt_strb;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (write_enable) begin
            protocol_error <= 1'b1;
          end
          // A word is finished when accepted or when it was skipped.
          if (!mem_req || mem_ready) begin
            if (index == LAST_IDX) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_wstrb <= '0;
            end else begin
              index     <= nxt_idx;
              mem_req   <= |nxt_strb;
              mem_addr  <= nxt_addr;
              mem_wdata <= nxt_data;
              mem_wstrb <= nxt_strb;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer_drain.sv
// Scoreboard bench for write_buffer_drain: the driver queues expected
// memory writes and done cycles, the monitor checks what the DUT presents.
module tb_write_buffer_drain;

  localparam int AW = 32;
  localparam int DS = 64;
  localparam int DW = 32;
  localparam int LW = 8 * DS;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_enable;
  logic [AW-1:0] address_in;
  logic [LW-1:0] data_in;
  logic [LW-1:0] mask_in;
  logic          done;
  logic          busy;
  logic          protocol_error;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;

  always #5 clk = ~clk;

  write_buffer_drain #(
    .ADDRESSIZE(AW),
    .DATASIZE  (DS),
    .DATA_WIDTH(DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .write_enable  (write_enable),
    .address_in    (address_in),
    .data_in       (data_in),
    .mask_in       (mask_in),
    .done          (done),
    .busy          (busy),
    .protocol_error(protocol_error),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
  } txn_t;

  txn_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [DW-1:0] seed, input int i);
    return seed ^ (i * 32'h0101_0101);
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [DW-1:0] seed);
    logic [LW-1:0] l;
    for (int i = 0; i < 16; i++) l[DW*i +: DW] = word_of(seed, i);
    return l;
  endfunction

  // expected full-mask writes of words [0, n) of a line at base
  task automatic push_full(input logic [AW-1:0] base, input logic [DW-1:0] seed, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{base + AW'(4 * i), word_of(seed, i), 4'hF});
  endtask

  // inputs change 1 time unit after the rising edge; cyc labels the cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Monitor: sample mid-cycle, pop on accepted writes and done pulses
  txn_t held;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_req", mem_req, 1);
        chk("stall_addr", mem_addr, held.addr);
        chk("stall_wdata", mem_wdata, held.data);
        chk("stall_wstrb", mem_wstrb, held.strb);
      end
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          chk("write_addr", mem_addr, t.addr);
          chk("write_data", mem_wdata, t.data);
          chk("write_strb", mem_wstrb, t.strb);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done_cycle", cyc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
        end
      end
      stall_prev = mem_req && !mem_ready;
      held = '{mem_addr, mem_wdata, mem_wstrb};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [LW-1:0] m;
    reset        = 1'b1;
    write_enable = 1'b0;
    mem_ready    = 1'b1;
    address_in   = '0;
    data_in      = '0;
    mask_in      = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", protocol_error, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);

    // full-mask line, memory always ready
    tick();
    c0 = cyc;
    address_in = 32'h0000_1234; data_in = line_of(32'hA5A5_0000); mask_in = '1;
    write_enable = 1'b1;
    push_full(32'h0000_1200, 32'hA5A5_0000, 16);
    done_q.push_back(c0 + 17);
    tick();
    write_enable = 1'b0;
    @(negedge clk);
    chk("busy_in_issue", busy, 1);
    wait_until(c0 + 19);

    // only word 5, byte 2 masked
    c0 = cyc;
    m = '0;
    m[5*DW +: DW] = 32'h00FF_0000;
    address_in = 32'h0000_1234; data_in = line_of(32'h1357_9BDF); mask_in = m;
    write_enable = 1'b1;
    exp_q.push_back('{32'h0000_1214, word_of(32'h1357_9BDF, 5), 4'b0100});
    done_q.push_back(c0 + 17);
    tick();
    write_enable = 1'b0;
    wait_until(c0 + 19);

    // memory stalls word 0 for three cycles
    c0 = cyc;
    address_in = 32'h0000_3000; data_in = line_of(32'h0BAD_F00D); mask_in = '1;
    write_enable = 1'b1;
    mem_ready = 1'b0;
    push_full(32'h0000_3000, 32'h0BAD_F00D, 16);
    done_q.push_back(c0 + 20);
    tick();
    write_enable = 1'b0;
    wait_until(c0 + 4);
    mem_ready = 1'b1;
    wait_until(c0 + 22);

    // back-to-back request issued in the done cycle
    c0 = cyc;
    address_in = 32'h0000_1000; data_in = line_of(32'h1111_0000); mask_in = '1;
    write_enable = 1'b1;
    push_full(32'h0000_1000, 32'h1111_0000, 16);
    done_q.push_back(c0 + 17);
    tick();
    write_enable = 1'b0;
    wait_until(c0 + 17);
    address_in = 32'h0000_2000; data_in = line_of(32'h2222_0000); mask_in = '1;
    write_enable = 1'b1;
    push_full(32'h0000_2000, 32'h2222_0000, 16);
    done_q.push_back(c0 + 34);
    tick();
    write_enable = 1'b0;
    @(negedge clk);
    chk("b2b_req", mem_req, 1);
    chk("b2b_addr", mem_addr, 32'h0000_2000);
    chk("b2b_busy", busy, 1);
    wait_until(c0 + 36);

    // write_enable during ISSUE is ignored and flagged
    c0 = cyc;
    address_in = 32'h0000_4000; data_in = line_of(32'h4444_0000); mask_in = '1;
    write_enable = 1'b1;
    push_full(32'h0000_4000, 32'h4444_0000, 16);
    done_q.push_back(c0 + 17);
    tick();
    write_enable = 1'b0;
    chk("perr_before", protocol_error, 0);
    wait_until(c0 + 5);
    address_in = 32'hBEEF_0000; data_in = '1;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    @(negedge clk);
    chk("perr_set", protocol_error, 1);
    wait_until(c0 + 19);
    chk("perr_sticky", protocol_error, 1);

    // reset in the middle of a line
    c0 = cyc;
    address_in = 32'h0000_5000; data_in = line_of(32'h5555_0000); mask_in = '1;
    write_enable = 1'b1;
    push_full(32'h0000_5000, 32'h5555_0000, 5);
    tick();
    write_enable = 1'b0;
    wait_until(c0 + 6);
    reset = 1'b1;
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_perr", protocol_error, 0);
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_wstrb", mem_wstrb, 0);
    repeat (25) tick();

    chk("writes_left", exp_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_buffer_drain.md
# write_buffer_drain

Memory-side responder for the cache write buffer: accepts one line-write request (address, line data, bit mask) on a single-cycle `write_enable` strobe, drains it into the word-wide main-memory port one word at a time with per-byte strobes, and pulses `done` when the line is fully written. It sits between the write buffer and the backing memory. It returns `done` on exactly the cycle the buffer needs to issue its next request back-to-back.

## Interface
Parameters:
- `ADDRESSIZE`, 32: address width in bits.
- `DATASIZE`, 64: line size in bytes.
- `DATA_WIDTH`, 32: memory word width in bits; WORDS = 8*DATASIZE/DATA_WIDTH (16).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `write_enable`  in  1  one-cycle request strobe from write buffer.
- `address_in`  in  ADDRESSIZE  line address; low log2(DATASIZE) bits ignored.
- `data_in`  in  8*DATASIZE  line data, word 0 in LSBs.
- `mask_in`  in  8*DATASIZE  bit mask, aligned with `data_in`.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  request latched and not yet completed.
- `protocol_error`  out  1  sticky; `write_enable` seen while busy.
- `mem_req`  out  1  memory write request.
- `mem_addr`  out  ADDRESSIZE  byte address of current word.
- `mem_wdata`  out  DATA_WIDTH  current word data.
- `mem_wstrb`  out  DATA_WIDTH/8  byte strobes.
- `mem_ready`  in  1  memory accepts when high together with `mem_req`.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: on `write_enable`, latch line address (offset bits forced to 0), data, and mask; set index=0; go ISSUE. The inputs are valid only in that cycle and must be latched.
- ISSUE: strobe bit b of word i = OR of `mask[DATA_WIDTH*i+8*b +: 8]`.
  - Strobe all zero: no request; index advances after one cycle (skip).
  - Strobe nonzero: `mem_req`=1 with stable `mem_addr` = {line_addr[hi:offset], i, 2'b00}, `mem_wdata` = word i, and `mem_wstrb`, held until the edge where `mem_ready`=1; then advance.
  - Last word completed or skipped: go DONE.
- DONE: `done`=1 for exactly one cycle. If `write_enable`=1 in this cycle, latch the new request and go directly to ISSUE. Otherwise go to IDLE.
- `write_enable` in ISSUE: request ignored, `protocol_error` set; cleared only by reset.
- `busy` = (state==ISSUE).
- Index counter is log2(WORDS) bits. Completion is detected at index==WORDS-1, never by counter wrap.

## Timing
- Reset values: state IDLE, `done`=0, `busy`=0, `protocol_error`=0, `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0.
- All outputs registered or decoded from registered state only; no combinational path from `write_enable` to any output.
- `write_enable` sampled at edge T: ISSUE from cycle T+1. With `mem_ready` tied high, one word per cycle; `done` in cycle T+1+WORDS (T+17).
- Each `mem_ready`-low cycle while `mem_req`=1 adds one cycle. Skipped words cost one cycle each.
- Back-to-back: `write_enable` during the `done` cycle gives the next ISSUE the following cycle, with no idle gap.
- Reset mid-operation: request abandoned, no `done`, outputs return to reset values next cycle.

## Structure
- Shared package `wb_drain_pkg`: state encoding (IDLE=2'b00, ISSUE=2'b01, DONE=2'b10), WORDS, OFFSET_BITS = log2(DATASIZE), INDEX_BITS = log2(WORDS).
- One sub-module, `mask_to_strobe`: combinational; maps DATA_WIDTH mask bits to DATA_WIDTH/8 byte strobes. Reused by the read-modify-write path later.

## Test plan
- Full-mask write, `address_in`=0x0000_1234, `mem_ready`=1: 16 requests at addresses 0x1200..0x123C, `mem_wstrb`=4'hF on each, `done` exactly 17 cycles after `write_enable`.
- Mask with only word 5, byte 2 bits set (0x00FF_0000): single request at line_addr+0x14 with `mem_wstrb`=4'b0100; `done` at T+17.
- `mem_ready` low for 3 cycles on word 0: `mem_addr`, `mem_wdata`, and `mem_wstrb` stable throughout; `done` at T+20.
- `write_enable` asserted in the `done` cycle with new address 0x2000: first request for 0x2000 in the next cycle, no gap; `done` pulses once per request.
- `write_enable` during ISSUE: ignored, `protocol_error`=1, current line completes normally. Then reset mid-ISSUE: no `done`, all outputs zero next cycle, `protocol_error` cleared.
